drain_counter: RTL and testbench

//  Read-side sequencer for the FFT-256 sample buffer. It pairs with the write-side fill

---
 rtl/fft_pkg.sv | 12 +
 rtl/drain_counter.sv | 110 +++++++++++
 tb/tb_drain_counter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT-256 sample buffer sequencers.
package fft_pkg;

   localparam int CNT_W = 7;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      FLUSH = 2'd2
   } drain_state_t;

endpackage

// File: rtl/drain_counter.sv
// Read-side sequencer for the FFT-256 sample buffer: walks addresses 0..thresh-1
// into a 1-cycle-latency RAM and presents each sample with valid/ready handshake.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no burst; waiting for start with a nonzero thresh
// READ  | issuing reads, one per cycle unless the output beat is stalled
// FLUSH | final read issued; waiting for the last beat to be accepted
module drain_counter #(
   parameter int CNT_W = fft_pkg::CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [CNT_W-1:0] thresh,
   input  logic             start,
   input  logic             out_ready,
   output logic             rd_en,
   output logic [CNT_W-1:0] rd_addr,
   output logic             out_valid,
   output logic             out_last,
   output logic             busy,
   output logic             empty,
   output logic             done,
   output logic             start_err
);

   import fft_pkg::*;

   drain_state_t     state;
   drain_state_t     state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] len;
   logic             last_rd;
   logic             start_ok;
   logic             last_acc;

   assign last_rd  = (cnt == len - CNT_W'(1));
   assign start_ok = (state == IDLE) && start && (thresh != '0);
   assign last_acc = out_valid && out_ready && out_last;
   assign rd_addr  = cnt;
   assign empty    = (state == IDLE);
   assign busy     = (state != IDLE);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and read strobe; a read is issued only when the output slot is free.
   always_comb begin
      state_nxt = state;
      rd_en     = 1'b0;
      case (state)
         IDLE: begin
            if (start_ok) state_nxt = READ;
         end
         READ: begin
            rd_en = !out_valid || out_ready;
            if (rd_en && last_rd) state_nxt = FLUSH;
         end
         FLUSH: begin
            if (last_acc) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Burst length capture and address counter; the counter stops at len-1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len <= '0;
         cnt <= '0;
      end else if (start_ok) begin
         len <= thresh;
         cnt <= '0;
      end else if (rd_en && !last_rd) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Output beat register: loads on a read, clears once accepted, holds while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else if (rd_en) begin
         out_valid <= 1'b1;
         out_last  <= last_rd;
      end else if (out_ready) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end
   end

   // Status pulses: done after the last accepted beat, start_err on a rejected start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done      <= 1'b0;
         start_err <= 1'b0;
      end else begin
         done      <= (state == FLUSH) && last_acc;
         start_err <= start && ((state != IDLE) || (thresh == '0));
      end
   end

endmodule

// File: tb/tb_drain_counter.sv
// Bench for drain_counter with a behavioural 1-cycle-latency RAM and a beat scoreboard.
module tb_drain_counter;

   localparam int W = 7;

   typedef struct {
      logic [7:0] data;
      logic       last;
   } beat_t;

   logic         clk;
   logic         rst_n;
   logic [W-1:0] thresh;
   logic         start;
   logic         out_ready;
   logic         rd_en;
   logic [W-1:0] rd_addr;
   logic         out_valid;
   logic         out_last;
   logic         busy;
   logic         empty;
   logic         done;
   logic         start_err;
   logic [7:0]   ram_q;

   beat_t sb[$];
   int    pass_cnt = 0;
   int    tot_cnt = 0;
   int    fail_cnt = 0;
   int    exp_addr, done_seen, err_seen, acc_cnt, rd_cnt, cyc;
   int    first_valid, done_cyc, last_acc_cyc;

   drain_counter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .thresh    (thresh),
      .start     (start),
      .out_ready (out_ready),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .out_valid (out_valid),
      .out_last  (out_last),
      .busy      (busy),
      .empty     (empty),
      .done      (done),
      .start_err (start_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] ram_word(input int a);
      return 8'((a * 7 + 3) & 8'hFF);
   endfunction

   // Synchronous RAM model with one cycle of read latency.
   always @(posedge clk) begin
      if (rd_en) ram_q <= ram_word(int'(rd_addr));
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tot_cnt++;
      assert (obs === expv) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // One clock: sample at the falling edge, then return just after the rising edge.
   task automatic tick();
      beat_t b;
      @(negedge clk);
      if (rd_en) begin
         rd_cnt++;
         chk("rd_addr", 32'(rd_addr), exp_addr);
         exp_addr++;
      end
      if (out_valid && !out_ready) chk("stall_no_read", 32'(rd_en), 0);
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (out_valid && out_ready) begin
         chk("sb_nonempty", 32'(sb.size() != 0), 1);
         if (sb.size() != 0) begin
            b = sb.pop_front();
            chk("beat_data", 32'(ram_q), 32'(b.data));
            chk("beat_last", 32'(out_last), 32'(b.last));
         end
         acc_cnt++;
         if (out_last) last_acc_cyc = cyc;
      end
      if (done) begin
         done_seen++;
         done_cyc = cyc;
         chk("empty_at_done", 32'(empty), 1);
      end
      if (start_err) err_seen++;
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_stats();
      exp_addr = 0; done_seen = 0; err_seen = 0; acc_cnt = 0; rd_cnt = 0;
      cyc = 0; first_valid = -1; done_cyc = -1; last_acc_cyc = -100;
   endtask

   // mode 0: out_ready always high; mode 1: out_ready high one cycle in three.
   // inj > 0: a second start (thresh=9) is driven at that cycle of the burst.
   task automatic run_burst(input int n, input int mode, input int inj);
      beat_t b;
      clear_stats();
      for (int i = 0; i < n; i++) begin
         b.data = ram_word(i);
         b.last = (i == n - 1);
         sb.push_back(b);
      end
      thresh    = W'(n);
      start     = 1'b1;
      out_ready = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k < 4000 && done_seen == 0; k++) begin
         out_ready = (mode == 0) || (k % 3 == 0);
         if (k == inj) begin
            start  = 1'b1;
            thresh = W'(9);
         end else begin
            start = 1'b0;
         end
         tick();
      end
      start     = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
      chk("done_once", done_seen, 1);
      chk("sb_drained", sb.size(), 0);
      chk("beat_count", acc_cnt, n);
      chk("addr_span", exp_addr, n);
      chk("first_valid_lat", first_valid, 2);
      chk("done_after_last", done_cyc, last_acc_cyc + 1);
      chk("empty_end", 32'(empty), 1);
      chk("start_err_cnt", err_seen, (inj > 0) ? 1 : 0);
   endtask

   initial begin
      rst_n = 1'b0; thresh = '0; start = 1'b0; out_ready = 1'b1;
      clear_stats();
      #2;
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_last", 32'(out_last), 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_start_err", 32'(start_err), 0);
      chk("rst_rd_en", 32'(rd_en), 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      tick();

      run_burst(4, 0, 0);
      run_burst(8, 1, 0);
      run_burst(1, 0, 0);
      run_burst(5, 0, 2);

      clear_stats();
      thresh = '0;
      start  = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      chk("zero_thresh_err", err_seen, 1);
      chk("zero_thresh_no_rd", rd_cnt, 0);
      chk("zero_thresh_empty", 32'(empty), 1);

      run_burst(127, 0, 0);

      // Reset while the third of six beats is on the bus.
      clear_stats();
      for (int i = 0; i < 6; i++) sb.push_back('{data: ram_word(i), last: (i == 5)});
      thresh = W'(6);
      start  = 1'b1;
      out_ready = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 20 && acc_cnt < 2; k++) tick();
      chk("pre_rst_valid", 32'(out_valid), 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 0);
      chk("mid_rst_last", 32'(out_last), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_empty", 32'(empty), 1);
      chk("mid_rst_rd_en", 32'(rd_en), 0);
      chk("mid_rst_done", 32'(done), 0);
      sb.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      tick();
      tick();
      chk("no_done_after_rst", done_seen, 0);
      run_burst(6, 0, 0);

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
